// File: rtl/svm_pkg.sv
// Shared definitions for the SVM score collector: default geometry, score width,
// FSM encoding and the layout of the buffered result record.
package svm_pkg;

   localparam int unsigned WINCOLS_DEF = 8;
   localparam int unsigned WPI_DEF     = 40;
   localparam int unsigned NROWS_DEF   = 64;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] ACC  = 1'b1;

   // Full-precision window score: 32-bit partials summed over wincols, plus the bias term.
   function automatic int unsigned score_width(input int unsigned wincols);
      return 32 + $clog2(wincols) + 1;
   endfunction

   // Record packs {score, detect, win, row} from MSB to LSB.
   function automatic int unsigned rec_det_bit(input int unsigned widx, input int unsigned ridx);
      return widx + ridx;
   endfunction

   function automatic int unsigned rec_score_lsb(input int unsigned widx, input int unsigned ridx);
      return widx + ridx + 1;
   endfunction

   function automatic int unsigned rec_width(input int unsigned swidth, input int unsigned widx,
                                             input int unsigned ridx);
      return swidth + widx + ridx + 1;
   endfunction

endpackage

// File: rtl/svm_score_collect_if.sv
// Result stream from the score collector to the detection/bbox stage (valid/ready).
interface svm_score_collect_if #(
   parameter int unsigned SWIDTH = 36,
   parameter int unsigned WIDX   = 6,
   parameter int unsigned RIDX   = 6
);
   logic                     out_valid;
   logic                     out_ready;
   logic signed [SWIDTH-1:0] out_score;
   logic                     out_detect;
   logic [WIDX-1:0]          out_win;
   logic [RIDX-1:0]          out_row;

   modport master (output out_valid, out_score, out_detect, out_win, out_row,
                   input  out_ready);
   modport slave  (input  out_valid, out_score, out_detect, out_win, out_row,
                   output out_ready);
endinterface

// File: rtl/svm_score_collect_fifo.sv
// Synchronous first-word-fall-through FIFO for result records; a push into a full
// FIFO is accepted only when a pop frees a slot in the same cycle.
module svm_result_fifo #(
   parameter int unsigned DW    = 44,
   parameter int unsigned DEPTH = 16
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          clr_i,
   input  logic          push_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          pop_i,
   output logic [DW-1:0] rdata_o,
   output logic          full_o,
   output logic          empty_o
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW:0]   wptr_q, wptr_d;
   logic [AW:0]   rptr_q, rptr_d;
   logic          do_push, do_pop;

   always_comb begin
      empty_o = (wptr_q == rptr_q);
      full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
      do_pop  = pop_i & ~empty_o;
      do_push = push_i & (~full_o | do_pop);
      rdata_o = mem_q[rptr_q[AW-1:0]];
      wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
      rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else if (clr_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end
endmodule

// File: rtl/svm_score_collect.sv
// Sums WINCOLS partial words per window from the row download bus, adds bias,
// thresholds, tags with window/row and queues results toward the detection stage.
module svm_score_collect
   import svm_pkg::*;
#(
   parameter  int unsigned WINCOLS = WINCOLS_DEF,
   parameter  int unsigned WPI     = WPI_DEF,
   parameter  int unsigned NROWS   = NROWS_DEF,
   parameter  int unsigned BWIDTH  = 32,
   parameter  int unsigned FDEPTH  = 16,
   localparam int unsigned SWIDTH  = score_width(WINCOLS),
   localparam int unsigned WIDX    = $clog2(WPI),
   localparam int unsigned RIDX    = $clog2(NROWS)
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     clr,
   input  logic                     dvo,
   input  logic signed [31:0]       svm_data,
   input  logic signed [BWIDTH-1:0] bias,
   input  logic signed [SWIDTH-1:0] threshold,
   svm_score_collect_if.master      res,
   output logic                     frame_end,
   output logic                     frag_err,
   output logic                     count_err,
   output logic                     ovf_err
);
   localparam int unsigned CW     = (WINCOLS > 1) ? $clog2(WINCOLS) : 1;
   localparam int unsigned NW     = $clog2(WPI + 2);
   localparam int unsigned RW     = rec_width(SWIDTH, WIDX, RIDX);
   localparam int unsigned DETB   = rec_det_bit(WIDX, RIDX);
   localparam int unsigned SC_LSB = rec_score_lsb(WIDX, RIDX);

   logic [0:0]               state_q, state_d;
   logic [CW-1:0]            col_q, col_d;
   logic [WIDX-1:0]          win_q, win_d;
   logic [NW-1:0]            nwin_q, nwin_d;
   logic [RIDX-1:0]          row_q, row_d;
   logic signed [SWIDTH-1:0] acc_q, acc_d;
   logic                     s_vld_q, s_vld_d;
   logic signed [SWIDTH-1:0] s_score_q, s_score_d;
   logic [WIDX-1:0]          s_win_q, s_win_d;
   logic [RIDX-1:0]          s_row_q, s_row_d;
   logic                     frame_q, frame_d;
   logic                     frag_q, frag_d;
   logic                     cnt_q, cnt_d;
   logic                     ovf_q, ovf_d;

   logic signed [SWIDTH-1:0] data_ext, bias_ext, acc_sum;
   logic                     win_last, row_last;
   logic [RW-1:0]            fifo_wdata, fifo_rdata;
   logic                     fifo_full, fifo_empty, fifo_pop;

   always_comb begin
      data_ext = SWIDTH'(svm_data);
      bias_ext = SWIDTH'(bias);
      acc_sum  = ((col_q == '0) ? '0 : acc_q) + data_ext;
      win_last = (col_q == CW'(WINCOLS - 1));
      row_last = (row_q == RIDX'(NROWS - 1));
   end

   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      win_d     = win_q;
      nwin_d    = nwin_q;
      row_d     = row_q;
      acc_d     = acc_q;
      s_vld_d   = 1'b0;
      s_score_d = s_score_q;
      s_win_d   = s_win_q;
      s_row_d   = s_row_q;
      frame_d   = 1'b0;
      frag_d    = frag_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q | (s_vld_q & fifo_full & ~fifo_pop);
      // IDLE and ACC accept a word identically; only a dvo drop in ACC ends the burst.
      if (dvo) begin
         state_d = ACC;
         acc_d   = acc_sum;
         if (win_last) begin
            col_d     = '0;
            s_vld_d   = 1'b1;
            s_score_d = acc_sum + bias_ext;
            s_win_d   = win_q;
            s_row_d   = row_q;
            if (win_q != WIDX'(WPI - 1)) win_d = win_q + 1'b1;
            if (nwin_q != NW'(WPI + 1)) nwin_d = nwin_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end else if (state_q == ACC) begin
         state_d = IDLE;
         col_d   = '0;
         win_d   = '0;
         nwin_d  = '0;
         if (col_q != '0) frag_d = 1'b1;
         if (nwin_q != NW'(WPI)) cnt_d = 1'b1;
         row_d   = row_last ? '0 : row_q + 1'b1;
         frame_d = row_last;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         col_q     <= '0;
         win_q     <= '0;
         nwin_q    <= '0;
         row_q     <= '0;
         acc_q     <= '0;
         s_vld_q   <= 1'b0;
         s_score_q <= '0;
         s_win_q   <= '0;
         s_row_q   <= '0;
         frame_q   <= 1'b0;
         frag_q    <= 1'b0;
         cnt_q     <= 1'b0;
         ovf_q     <= 1'b0;
      end else if (clr) begin
         state_q   <= IDLE;
         col_q     <= '0;
         win_q     <= '0;
         nwin_q    <= '0;
         row_q     <= '0;
         acc_q     <= '0;
         s_vld_q   <= 1'b0;
         s_score_q <= '0;
         s_win_q   <= '0;
         s_row_q   <= '0;
         frame_q   <= 1'b0;
         frag_q    <= 1'b0;
         cnt_q     <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         win_q     <= win_d;
         nwin_q    <= nwin_d;
         row_q     <= row_d;
         acc_q     <= acc_d;
         s_vld_q   <= s_vld_d;
         s_score_q <= s_score_d;
         s_win_q   <= s_win_d;
         s_row_q   <= s_row_d;
         frame_q   <= frame_d;
         frag_q    <= frag_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
      end
   end

   // Threshold is compared in the push cycle so it is sampled one cycle after bias.
   always_comb begin
      fifo_wdata = {s_score_q, (s_score_q > threshold), s_win_q, s_row_q};
      fifo_pop   = res.out_ready & ~fifo_empty;
   end

   svm_result_fifo #(
      .DW    (RW),
      .DEPTH (FDEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .clr_i   (clr),
      .push_i  (s_vld_q),
      .wdata_i (fifo_wdata),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      res.out_valid  = ~fifo_empty;
      res.out_score  = fifo_empty ? '0 : $signed(fifo_rdata[SC_LSB +: SWIDTH]);
      res.out_detect = fifo_empty ? 1'b0 : fifo_rdata[DETB];
      res.out_win    = fifo_empty ? '0 : fifo_rdata[RIDX +: WIDX];
      res.out_row    = fifo_empty ? '0 : fifo_rdata[RIDX-1:0];
      frame_end      = frame_q;
      frag_err       = frag_q;
      count_err      = cnt_q;
      ovf_err        = ovf_q;
   end
endmodule
